sync_timing_gen: RTL and testbench

Raster sync generator for the video path. It produces the active-high HSYNC/VSYNC pulses, data-enable, and pixel/line coordinates. It is the transmit-side counterpart of the line-position counter. That counter clears on HSYNC and counts pixels, so this block's HSYNC leading edge defines pixel position 0 of every line. It sits at the head of the display/test-pattern pipeline and drives both the pattern source and the sync outputs.

---
 rtl/sync_timing_pkg.sv | 42 ++++
 rtl/sync_phase_fsm.sv | 61 ++++++
 rtl/sync_timing_gen.sv | 159 +++++++++++++++
 tb/tb_sync_timing_gen.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sync_timing_pkg.sv
// sync_timing_pkg: shared types and helpers for the raster sync generator.
//   phase_e      - four-phase raster ordering SYNC -> BP -> ACT -> FP
//   next_phase   - successor phase (FP wraps to SYNC)
//   h_total      - clocks per line from the horizontal phase widths
//   v_total      - lines per frame from the vertical phase widths
//   params_ok    - legality of a phase set against a counter width
package sync_timing_pkg;

  typedef enum logic [1:0] {
    SYNC = 2'd0,
    BP   = 2'd1,
    ACT  = 2'd2,
    FP   = 2'd3
  } phase_e;

  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      SYNC:    return BP;
      BP:      return ACT;
      ACT:     return FP;
      default: return SYNC;
    endcase
  endfunction

  function automatic int h_total(input int sync_w, input int bp_w,
                                 input int act_w, input int fp_w);
    return sync_w + bp_w + act_w + fp_w;
  endfunction

  function automatic int v_total(input int sync_w, input int bp_w,
                                 input int act_w, input int fp_w);
    return sync_w + bp_w + act_w + fp_w;
  endfunction

  // Every phase must be at least one unit long and the total must fit in cw bits.
  function automatic bit params_ok(input int sync_w, input int bp_w,
                                   input int act_w, input int fp_w, input int cw);
    return (sync_w >= 1) && (bp_w >= 1) && (act_w >= 1) && (fp_w >= 1) &&
           ((sync_w + bp_w + act_w + fp_w) < (1 << cw));
  endfunction

endpackage

// File: rtl/sync_phase_fsm.sv
// sync_phase_fsm: four-phase raster sequencer with a down-counting phase timer.
//   clk, rst            - clock, asynchronous active-high reset
//   step                - advance one unit (pixel or line)
//   len_sync/bp/act/fp  - phase lengths in units (each >= 1)
//   state               - current phase
//   cnt                 - units remaining in the phase, minus one
//   wrap                - combinational: this step leaves FP for SYNC
// Reset parks the sequencer at the last unit of FP so the first step enters SYNC.
import sync_timing_pkg::*;

module sync_phase_fsm #(
  parameter int CW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          step,
  input  logic [CW-1:0] len_sync,
  input  logic [CW-1:0] len_bp,
  input  logic [CW-1:0] len_act,
  input  logic [CW-1:0] len_fp,
  output phase_e        state,
  output logic [CW-1:0] cnt,
  output logic          wrap
);

  phase_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (step) begin
      if (cnt_q == '0) begin
        state_d = next_phase(state_q);
        case (state_d)
          SYNC:    cnt_d = len_sync - 1'b1;
          BP:      cnt_d = len_bp - 1'b1;
          ACT:     cnt_d = len_act - 1'b1;
          default: cnt_d = len_fp - 1'b1;
        endcase
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FP;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;
  assign cnt   = cnt_q;
  assign wrap  = step && (state_q == FP) && (cnt_q == '0);

endmodule

// File: rtl/sync_timing_gen.sv
// sync_timing_gen: raster sync generator (HSYNC/VSYNC/DE plus active coordinates).
//   clk, rst     - pixel clock, asynchronous active-high reset
//   en           - advance one pixel per clock; everything holds while low
//   hsync, vsync - active-high sync pulses (vsync edges coincide with hcnt -> 0)
//   de           - high while both axes are in their active phase
//   x, y         - active pixel / line index, 0 outside de
//   line_start   - one-clock pulse on each edge where hcnt becomes 0
//   frame_start  - one-clock pulse when hcnt and vcnt both become 0
//   frame_cnt    - (only with SYNC_TIMING_GEN_FRAME_CNT_EN) 16-bit frame counter,
//                  starts at 0 on the first frame after reset
// All outputs are registered from the next-position values, so they change on
// the same edge as the raster counters.
import sync_timing_pkg::*;

module sync_timing_gen #(
  parameter int H_ACTIVE = 8,
  parameter int H_FP     = 2,
  parameter int H_SYNC   = 3,
  parameter int H_BP     = 2,
  parameter int V_ACTIVE = 4,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 1,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          line_start,
  output logic          frame_start
`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
  ,
  output logic [15:0]   frame_cnt
`else
`endif
);

  localparam int H_TOTAL = h_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
  localparam int V_TOTAL = v_total(V_SYNC, V_BP, V_ACTIVE, V_FP);

  if (!params_ok(H_SYNC, H_BP, H_ACTIVE, H_FP, CW) ||
      !params_ok(V_SYNC, V_BP, V_ACTIVE, V_FP, CW)) begin : g_bad_params
    $error("sync_timing_gen: illegal phase widths or CW too small");
  end

  localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] X_OFS  = CW'(H_SYNC + H_BP);
  localparam logic [CW-1:0] Y_OFS  = CW'(V_SYNC + V_BP);

  phase_e        h_state, v_state, h_state_nx, v_state_nx;
  logic [CW-1:0] h_cnt, v_cnt;
  logic          h_wrap, v_wrap;

  // Horizontal steps every enabled pixel; vertical only on the line wrap.
  sync_phase_fsm #(.CW(CW)) u_h_fsm (
    .clk      (clk),
    .rst      (rst),
    .step     (en),
    .len_sync (CW'(H_SYNC)),
    .len_bp   (CW'(H_BP)),
    .len_act  (CW'(H_ACTIVE)),
    .len_fp   (CW'(H_FP)),
    .state    (h_state),
    .cnt      (h_cnt),
    .wrap     (h_wrap)
  );

  sync_phase_fsm #(.CW(CW)) u_v_fsm (
    .clk      (clk),
    .rst      (rst),
    .step     (h_wrap),
    .len_sync (CW'(V_SYNC)),
    .len_bp   (CW'(V_BP)),
    .len_act  (CW'(V_ACTIVE)),
    .len_fp   (CW'(V_FP)),
    .state    (v_state),
    .cnt      (v_cnt),
    .wrap     (v_wrap)
  );

  logic [CW-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
  logic          hsync_d, vsync_d, de_d, line_start_d, frame_start_d;
  logic [CW-1:0] x_d, y_d;

  // Next raster position: outputs are decoded from it so they share the edge
  // with the counters. Pulses follow the wraps, which are gated by en.
  always_comb begin
    h_state_nx = (en && h_cnt == '0) ? next_phase(h_state) : h_state;
    v_state_nx = (h_wrap && v_cnt == '0) ? next_phase(v_state) : v_state;

    hcnt_d = hcnt_q;
    if (en) hcnt_d = h_wrap ? '0 : hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (h_wrap) vcnt_d = v_wrap ? '0 : vcnt_q + 1'b1;

    hsync_d       = (h_state_nx == SYNC);
    vsync_d       = (v_state_nx == SYNC);
    de_d          = (h_state_nx == ACT) && (v_state_nx == ACT);
    x_d           = de_d ? hcnt_d - X_OFS : '0;
    y_d           = de_d ? vcnt_d - Y_OFS : '0;
    line_start_d  = h_wrap;
    frame_start_d = v_wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt_q      <= H_LAST;
      vcnt_q      <= V_LAST;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      de          <= 1'b0;
      x           <= '0;
      y           <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      hcnt_q      <= hcnt_d;
      vcnt_q      <= vcnt_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
      de          <= de_d;
      x           <= x_d;
      y           <= y_d;
      line_start  <= line_start_d;
      frame_start <= frame_start_d;
    end
  end

`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
  // The first frame after reset is frame 0, so counting starts on the second.
  logic        seen_q, seen_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    seen_d      = seen_q | v_wrap;
    frame_cnt_d = (v_wrap && seen_q) ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seen_q      <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      seen_q      <= seen_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`else
`endif

endmodule

// File: tb/tb_sync_timing_gen.sv
module tb_sync_timing_gen;

  localparam int CW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en  = 1'b0;
  logic          hsync, vsync, de, line_start, frame_start;
  logic [CW-1:0] x, y;
`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  int checks = 0;
  int passes = 0;

  sync_timing_gen dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_start  (line_start),
    .frame_start (frame_start)
`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
    ,
    .frame_cnt   (frame_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Expected {hsync,vsync,de,line_start,frame_start,x,y} at the n-th enabled
  // edge after reset (n >= 1), from the default raster: 15 clocks x 8 lines,
  // sync 3 / bp 2 / active 8 / fp 2 horizontally, 2 / 1 / 4 / 1 vertically.
  function automatic logic [28:0] model(input int n);
    int hc, vc;
    logic hs, vs, d, ls, fs;
    logic [CW-1:0] ex, ey;
    hc = (n - 1) % 15;
    vc = ((n - 1) / 15) % 8;
    hs = (hc < 3);
    vs = (vc < 2);
    d  = (hc >= 5) && (hc < 13) && (vc >= 3) && (vc < 7);
    ls = (hc == 0);
    fs = (hc == 0) && (vc == 0);
    ex = d ? 12'(hc - 5) : 12'd0;
    ey = d ? 12'(vc - 3) : 12'd0;
    return {hs, vs, d, ls, fs, ex, ey};
  endfunction

  function automatic logic [28:0] observed();
    return {hsync, vsync, de, line_start, frame_start, x, y};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    en  = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (observed() !== 29'd0)
      $display("FAIL reset_outputs: got %h expected 0", observed());
    else passes++;
`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
    checks++;
    if (frame_cnt !== 16'd0)
      $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt);
    else passes++;
`endif
    en  = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_first_line();
    logic exp_hs;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 16; n++) begin
      tick();
      exp_hs = (n <= 3) || (n == 16);
      checks++;
      if (hsync !== exp_hs)
        $display("FAIL first_line_hsync edge %0d: got %b expected %b", n, hsync, exp_hs);
      else passes++;
      checks++;
      if (vsync !== 1'b1)
        $display("FAIL first_line_vsync edge %0d: got %b expected 1", n, vsync);
      else passes++;
      if (n == 1) begin
        checks++;
        if ({line_start, frame_start} !== 2'b11)
          $display("FAIL first_edge_pulses: got ls=%b fs=%b expected 1 1", line_start, frame_start);
        else passes++;
      end
      if (n == 16) begin
        checks++;
        if ({line_start, frame_start} !== 2'b10)
          $display("FAIL edge16_pulses: got ls=%b fs=%b expected 1 0", line_start, frame_start);
        else passes++;
      end
    end
    en = 1'b0;
  endtask

  task automatic test_free_run();
    int de_count, first_de, last_de, vs_count, last_vs;
    logic [28:0] exp_v;
    de_count = 0; first_de = 0; last_de = 0; vs_count = 0; last_vs = 0;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 121; n++) begin
      tick();
      exp_v = model(n);
      checks++;
      if (observed() !== exp_v)
        $display("FAIL free_run edge %0d: got %h expected %h", n, observed(), exp_v);
      else passes++;
      if (n <= 120) begin
        if (de) begin
          de_count++;
          if (first_de == 0) first_de = n;
          last_de = n;
        end
        if (vsync) begin
          vs_count++;
          last_vs = n;
        end
      end
      if (n == 51) begin
        checks++;
        if ({de, x, y} !== {1'b1, 12'd0, 12'd0})
          $display("FAIL first_active_pixel: got de=%b x=%0d y=%0d expected 1 0 0", de, x, y);
        else passes++;
      end
      if (n == 58) begin
        checks++;
        if ({de, x} !== {1'b1, 12'd7})
          $display("FAIL line_last_pixel: got de=%b x=%0d expected 1 7", de, x);
        else passes++;
      end
      if (n == 59) begin
        checks++;
        if ({de, x, y} !== 25'd0)
          $display("FAIL after_active: got de=%b x=%0d y=%0d expected 0 0 0", de, x, y);
        else passes++;
      end
      if (n == 103) begin
        checks++;
        if ({de, x, y} !== {1'b1, 12'd7, 12'd3})
          $display("FAIL last_active_pixel: got de=%b x=%0d y=%0d expected 1 7 3", de, x, y);
        else passes++;
      end
      if (n == 121) begin
        checks++;
        if (frame_start !== 1'b1)
          $display("FAIL second_frame_start: got %b expected 1", frame_start);
        else passes++;
      end
    end
    en = 1'b0;
    checks++;
    if (first_de != 51 || last_de != 103)
      $display("FAIL de_window: got first=%0d last=%0d expected 51 103", first_de, last_de);
    else passes++;
    checks++;
    if (de_count != 32)
      $display("FAIL de_count: got %0d expected 32", de_count);
    else passes++;
    checks++;
    if (vs_count != 30 || last_vs != 30)
      $display("FAIL vsync_span: got count=%0d last=%0d expected 30 30", vs_count, last_vs);
    else passes++;
  endtask

  task automatic test_en_toggle();
    int n;
    logic [28:0] exp_v, prev;
    n = 0;
    prev = '0;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      en = 1'($urandom_range(0, 1));
      tick();
      if (en) begin
        n++;
        exp_v = model(n);
      end else begin
        // Held raster: level outputs keep their value, pulses drop.
        exp_v = prev & ~(29'b11 << 24);
      end
      checks++;
      if (observed() !== exp_v)
        $display("FAIL en_toggle cycle %0d (pixel %0d): got %h expected %h", c, n, observed(), exp_v);
      else passes++;
      prev = exp_v;
    end
    en = 1'b0;
  endtask

  task automatic test_rst_mid();
    do_reset();
    en = 1'b1;
    repeat (70) tick();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (observed() !== 29'd0)
      $display("FAIL rst_immediate: got %h expected 0", observed());
    else passes++;
    tick();
    checks++;
    if (observed() !== 29'd0)
      $display("FAIL rst_held: got %h expected 0", observed());
    else passes++;
    rst = 1'b0;
    tick();
    checks++;
    if (observed() !== model(1))
      $display("FAIL rst_restart: got %h expected %h", observed(), model(1));
    else passes++;
    tick();
    checks++;
    if (observed() !== model(2))
      $display("FAIL rst_restart_edge2: got %h expected %h", observed(), model(2));
    else passes++;
    en = 1'b0;
  endtask

`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
  task automatic test_frame_cnt();
    int k;
    bit seen;
    k = 0;
    do_reset();
    en = 1'b1;
    for (int n = 1; n <= 241; n++) begin
      tick();
      if (frame_start) begin
        checks++;
        if (frame_cnt !== 16'(k))
          $display("FAIL frame_cnt_seq frame %0d: got %0d expected %0d", k, frame_cnt, k);
        else passes++;
        k++;
      end
    end
    checks++;
    if (k != 3)
      $display("FAIL frame_start_count: got %0d expected 3", k);
    else passes++;
    repeat (5) tick();
    force dut.frame_cnt_q = 16'hFFFF;
    #1 release dut.frame_cnt_q;
    seen = 1'b0;
    for (int c = 0; c < 130 && !seen; c++) begin
      tick();
      if (frame_start) seen = 1'b1;
    end
    checks++;
    if (!seen)
      $display("FAIL frame_cnt_wrap: no frame_start within 130 edges");
    else if (frame_cnt !== 16'd0)
      $display("FAIL frame_cnt_wrap: got %h expected 0000", frame_cnt);
    else passes++;
    en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_first_line();
    test_free_run();
    test_en_toggle();
    test_rst_mid();
`ifdef SYNC_TIMING_GEN_FRAME_CNT_EN
    test_frame_cnt();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
